// File: rtl/demux_bank_if.sv
// demux_bank_if -- write handshake bundle for demux_bank.
//
// Signals:
//   wr_valid  writer -> bank  write request qualifier
//   wr_ready  bank -> writer  bank accepts a write this cycle
//   wr_sel    writer -> bank  destination entry index 0..15
//   wr_data   writer -> bank  write data, DATA_W bits
//
// Modports:
//   master  the writer side
//   slave   the bank side
interface demux_bank_if #(
  parameter int DATA_W = 16
) ();

  logic              wr_valid;
  logic              wr_ready;
  logic [3:0]        wr_sel;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_sel,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_sel,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/demux_bank.sv
// demux_bank -- sixteen-entry register bank with an indexed write port and a
// sequential clear sweep.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   clr_start  request to start a clear sweep
//   wr         write handshake (demux_bank_if.slave): wr_valid, wr_ready,
//              wr_sel, wr_data
//   q0..q15    registered entry contents, feeding the 16-to-1 select mux
//   entry_vld  bit i set when entry i was written since last reset or clear
//   busy       high while a clear sweep runs
//   clr_done   one-cycle pulse after the last sweep step
module demux_bank #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start,
  demux_bank_if.slave       wr,
  output logic [DATA_W-1:0] q0,
  output logic [DATA_W-1:0] q1,
  output logic [DATA_W-1:0] q2,
  output logic [DATA_W-1:0] q3,
  output logic [DATA_W-1:0] q4,
  output logic [DATA_W-1:0] q5,
  output logic [DATA_W-1:0] q6,
  output logic [DATA_W-1:0] q7,
  output logic [DATA_W-1:0] q8,
  output logic [DATA_W-1:0] q9,
  output logic [DATA_W-1:0] q10,
  output logic [DATA_W-1:0] q11,
  output logic [DATA_W-1:0] q12,
  output logic [DATA_W-1:0] q13,
  output logic [DATA_W-1:0] q14,
  output logic [DATA_W-1:0] q15,
  output logic [15:0]       entry_vld,
  output logic              busy,
  output logic              clr_done
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_r;
  logic [3:0]        cnt_r;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [15:0]       vld_r;
  logic              busy_r;
  logic              clr_done_r;
  logic              wr_ready_s;

  // A pending clear request blocks the write port in the same cycle, so a
  // concurrent write is simply not accepted and the writer keeps holding it.
  assign wr_ready_s  = (state_r == IDLE) && !clr_start && !rst;
  assign wr.wr_ready = wr_ready_s;

  // Bank state, sweep FSM and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      vld_r      <= 16'h0000;
      busy_r     <= 1'b0;
      clr_done_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      clr_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (clr_start) begin
            state_r <= CLEAR;
            busy_r  <= 1'b1;
            cnt_r   <= 4'd0;
          end else if (wr.wr_valid) begin
            mem_r[wr.wr_sel] <= wr.wr_data;
            vld_r[wr.wr_sel] <= 1'b1;
          end
        end
        CLEAR: begin
          // One entry per cycle; clr_start is deliberately not looked at here.
          mem_r[cnt_r] <= '0;
          vld_r[cnt_r] <= 1'b0;
          cnt_r        <= cnt_r + 4'd1;
          if (cnt_r == 4'd15) begin
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            clr_done_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

  assign q0  = mem_r[0];
  assign q1  = mem_r[1];
  assign q2  = mem_r[2];
  assign q3  = mem_r[3];
  assign q4  = mem_r[4];
  assign q5  = mem_r[5];
  assign q6  = mem_r[6];
  assign q7  = mem_r[7];
  assign q8  = mem_r[8];
  assign q9  = mem_r[9];
  assign q10 = mem_r[10];
  assign q11 = mem_r[11];
  assign q12 = mem_r[12];
  assign q13 = mem_r[13];
  assign q14 = mem_r[14];
  assign q15 = mem_r[15];

  assign entry_vld = vld_r;
  assign busy      = busy_r;
  assign clr_done  = clr_done_r;

endmodule

// File: tb/tb_demux_bank.sv
// tb_demux_bank -- directed bench for demux_bank.
module tb_demux_bank;

  logic        clk;
  logic        rst;
  logic        clr_start;
  logic [15:0] q [16];
  logic [15:0] entry_vld;
  logic        busy;
  logic        clr_done;

  int checks_r;
  int errors_r;
  int pulses_r;

  demux_bank_if #(.DATA_W(16)) wif ();

  demux_bank #(.DATA_W(16), .DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr_start (clr_start),
    .wr        (wif.slave),
    .q0  (q[0]),  .q1  (q[1]),  .q2  (q[2]),  .q3  (q[3]),
    .q4  (q[4]),  .q5  (q[5]),  .q6  (q[6]),  .q7  (q[7]),
    .q8  (q[8]),  .q9  (q[9]),  .q10 (q[10]), .q11 (q[11]),
    .q12 (q[12]), .q13 (q[13]), .q14 (q[14]), .q15 (q[15]),
    .entry_vld (entry_vld),
    .busy      (busy),
    .clr_done  (clr_done)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_r++;
    if (got !== exp) begin
      errors_r++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("%s_q%0d", tag, i), {16'h0, q[i]}, 32'h0);
    end
  endtask

  task automatic fill(input logic [15:0] base);
    for (int k = 0; k < 16; k++) begin
      wif.wr_valid = 1'b1;
      wif.wr_sel   = 4'(k);
      wif.wr_data  = base + 16'(k);
      #1;
      check($sformatf("fill_ready%0d", k), {31'h0, wif.wr_ready}, 32'h1);
      tick();
    end
    wif.wr_valid = 1'b0;
  endtask

  initial begin
    checks_r     = 0;
    errors_r     = 0;
    pulses_r     = 0;
    rst          = 1'b1;
    clr_start    = 1'b0;
    wif.wr_valid = 1'b0;
    wif.wr_sel   = 4'd0;
    wif.wr_data  = 16'h0000;

    // Reset state.
    tick();
    tick();
    check_all_zero("rst");
    check("rst_vld", {16'h0, entry_vld}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, clr_done}, 32'h0);
    check("rst_ready", {31'h0, wif.wr_ready}, 32'h0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'h0, wif.wr_ready}, 32'h1);

    // Single write to entry 3.
    wif.wr_valid = 1'b1;
    wif.wr_sel   = 4'd3;
    wif.wr_data  = 16'hBEEF;
    tick();
    wif.wr_valid = 1'b0;
    check("w3_q3", {16'h0, q[3]}, 32'hBEEF);
    check("w3_vld", {16'h0, entry_vld}, 32'h0008);
    for (int i = 0; i < 16; i++) begin
      if (i != 3) check($sformatf("w3_q%0d", i), {16'h0, q[i]}, 32'h0);
    end

    // Back-to-back writes to every entry.
    fill(16'h1000);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("fill_q%0d", k), {16'h0, q[k]}, 32'h1000 + k);
    end
    check("fill_vld", {16'h0, entry_vld}, 32'hFFFF);

    // Clear sweep, entries zeroed in order.
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("sw_busy%0d", i), {31'h0, busy}, 32'h1);
      check($sformatf("sw_ready%0d", i), {31'h0, wif.wr_ready}, 32'h0);
      check($sformatf("sw_qi%0d", i), {16'h0, q[i]}, 32'h1000 + i);
      if (i > 0) check($sformatf("sw_qprev%0d", i), {16'h0, q[i-1]}, 32'h0);
      check($sformatf("sw_vld%0d", i), {16'h0, entry_vld}, {16'h0, 16'hFFFF << i});
      check($sformatf("sw_done%0d", i), {31'h0, clr_done}, 32'h0);
      tick();
    end
    check("sw_end_done", {31'h0, clr_done}, 32'h1);
    check("sw_end_busy", {31'h0, busy}, 32'h0);
    check("sw_end_vld", {16'h0, entry_vld}, 32'h0);
    check("sw_end_ready", {31'h0, wif.wr_ready}, 32'h1);
    check_all_zero("sw_end");
    tick();
    check("sw_done_once", {31'h0, clr_done}, 32'h0);

    // Write held across a whole sweep lands just after it.
    clr_start = 1'b1;
    tick();
    clr_start    = 1'b0;
    wif.wr_valid = 1'b1;
    wif.wr_sel   = 4'd5;
    wif.wr_data  = 16'h00AA;
    for (int i = 0; i < 16; i++) begin
      #1;
      check($sformatf("hold_ready%0d", i), {31'h0, wif.wr_ready}, 32'h0);
      check($sformatf("hold_q5_%0d", i), {16'h0, q[5]}, 32'h0);
      tick();
    end
    check("hold_end_done", {31'h0, clr_done}, 32'h1);
    check("hold_end_ready", {31'h0, wif.wr_ready}, 32'h1);
    check("hold_end_q5", {16'h0, q[5]}, 32'h0);
    tick();
    wif.wr_valid = 1'b0;
    check("hold_q5", {16'h0, q[5]}, 32'h00AA);
    check("hold_vld", {16'h0, entry_vld}, 32'h0020);

    // clr_start beats a concurrent write; a repeat request mid-sweep is ignored.
    clr_start    = 1'b1;
    wif.wr_valid = 1'b1;
    wif.wr_sel   = 4'd9;
    wif.wr_data  = 16'h1234;
    #1;
    check("race_ready", {31'h0, wif.wr_ready}, 32'h0);
    tick();
    clr_start    = 1'b0;
    wif.wr_valid = 1'b0;
    check("race_q9", {16'h0, q[9]}, 32'h0);
    check("race_vld", {16'h0, entry_vld}, 32'h0020);
    for (int c = 0; c < 16; c++) begin
      clr_start = (c == 8) ? 1'b1 : 1'b0;
      check($sformatf("race_busy%0d", c), {31'h0, busy}, 32'h1);
      check($sformatf("race_done%0d", c), {31'h0, clr_done}, 32'h0);
      tick();
    end
    clr_start = 1'b0;
    check("race_end_done", {31'h0, clr_done}, 32'h1);
    check("race_end_busy", {31'h0, busy}, 32'h0);
    check("race_end_q9", {16'h0, q[9]}, 32'h0);
    check("race_end_vld", {16'h0, entry_vld}, 32'h0);
    tick();
    check("race_after_done", {31'h0, clr_done}, 32'h0);
    check("race_after_busy", {31'h0, busy}, 32'h0);

    // Reset mid-sweep aborts without a done pulse.
    fill(16'h2000);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("abort_pre_q5", {16'h0, q[5]}, 32'h0);
    check("abort_pre_q7", {16'h0, q[7]}, 32'h2007);
    check("abort_pre_q15", {16'h0, q[15]}, 32'h200F);
    check("abort_pre_busy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("abort");
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_vld", {16'h0, entry_vld}, 32'h0);
    for (int i = 0; i < 20; i++) begin
      if (clr_done) pulses_r++;
      tick();
    end
    check("abort_no_done", pulses_r, 32'h0);
    check("abort_idle_busy", {31'h0, busy}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

endmodule

// File: doc/demux_bank.md
DEMUX_BANK -- requirements
Module: demux_bank

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, the width of each stored word and of the write data.
REQ-002 The block SHALL have parameter DEPTH, default 16, the number of entries; it is fixed at 16 and addressed by a 4-bit select.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port clr_start, input, 1, a request to start a clear sweep.
REQ-006 The block SHALL have port wr_valid, input, 1, write request qualifier.
REQ-007 The block SHALL have port wr_ready, output, 1, indicating the block accepts a write this cycle.
REQ-008 The block SHALL have port wr_sel, input, 4, the destination entry index 0..15.
REQ-009 The block SHALL have port wr_data, input, DATA_W, the write data.
REQ-010 The block SHALL have ports q0..q15, output, DATA_W each, the registered entry contents; these feed the 16-to-1 select mux.
REQ-011 The block SHALL have port entry_vld, output, 16, where bit i=1 means entry i was written since the last reset or clear.
REQ-012 The block SHALL have port busy, output, 1, high while a clear sweep runs.
REQ-013 The block SHALL have port clr_done, output, 1, a one-cycle pulse when a clear sweep completes.

Function
REQ-014 The block SHALL use a two-state FSM: IDLE and CLEAR.
REQ-015 wr_ready SHALL be combinational and equal (state==IDLE) && !clr_start && !rst.
REQ-016 A write handshake SHALL occur on a rising edge where wr_valid && wr_ready; at that edge entry wr_sel <= wr_data and entry_vld[wr_sel] <= 1. No other entry changes.
REQ-017 Write latency SHALL be one cycle: the new value appears on q<wr_sel> immediately after the handshake edge.
REQ-018 Writes without a handshake SHALL be ignored and not queued; the writer holds wr_valid, wr_sel and wr_data until a handshake occurs.
REQ-019 In IDLE, clr_start=1 SHALL move the FSM to CLEAR at the next edge with sweep counter cnt=0; clr_start wins over a concurrent wr_valid, because wr_ready is 0 in that cycle.
REQ-020 In CLEAR, each edge SHALL zero entry cnt, clear entry_vld[cnt] and increment cnt (4-bit).
REQ-021 At the edge where cnt==15, the FSM SHALL return to IDLE and assert clr_done for exactly the following cycle; the sweep therefore takes 16 cycles.
REQ-022 busy SHALL be 1 exactly while state==CLEAR.
REQ-023 clr_start asserted during CLEAR SHALL be ignored and SHALL NOT restart or extend the sweep.
REQ-024 clr_start held high continuously SHALL start a new sweep on the first IDLE cycle after clr_done, i.e. back-to-back sweeps.
REQ-025 Entry and entry_vld contents SHALL change only by a write handshake, a sweep step, or reset.

Reset
REQ-026 While rst=1 at an edge, the block SHALL set all q0..q15=0, entry_vld=0, state=IDLE, cnt=0, busy=0 and clr_done=0; wr_ready is 0 while rst=1.
REQ-027 Reset SHALL take priority over writes and sweeps; rst asserted mid-sweep aborts the sweep with no clr_done pulse.
REQ-028 On the first cycle after rst deasserts, wr_ready SHALL be 1 provided clr_start=0.

Verification
REQ-029 Reset, then write sel=3 data=0xBEEF with wr_valid=1 for one cycle -> q3=0xBEEF and entry_vld=0x0008 next cycle; all other q=0.
REQ-030 Write sel=k data=0x1000+k for k=0..15 back-to-back -> wr_ready stays 1, each qk=0x1000+k, entry_vld=0xFFFF.
REQ-031 With all entries filled, pulse clr_start -> busy=1 for 16 cycles, entries zero in order 0..15, then clr_done=1 for one cycle, then entry_vld=0 and wr_ready=1.
REQ-032 Hold wr_valid=1 with sel=5 data=0x00AA across a whole sweep -> wr_ready=0 throughout; the write lands one cycle after the sweep ends, giving q5=0x00AA and entry_vld=0x0020.
REQ-033 Apply clr_start and wr_valid in the same IDLE cycle -> no write occurs and the sweep starts; a second clr_start pulse at sweep cycle 8 has no effect, and clr_done fires 16 cycles after the start.
REQ-034 Assert rst at sweep cycle 6 with entries 7..15 nonzero -> all q=0, busy=0 and no clr_done pulse.
